// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain with per-stage stall, flush,
// downstream back-pressure, occupancy and a saturating stall counter.
module pipe_reg_chain #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STAGES  = 4,
  parameter logic [31:0] NOP_VAL = 32'h0000_0013,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic [STAGES-1:0]             stall_req,
  input  logic [STAGES-1:0]             flush,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [STAGES-1:0]             stage_valid,
  output logic [STAGES*WIDTH-1:0]       stage_data,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]              stall_count,
  input  logic                          cnt_clr
);

  localparam int unsigned OCC_W = $clog2(STAGES+1);
  localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_VAL);

  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0]             vld_d;
  logic [STAGES-1:0][WIDTH-1:0]  dat_q;
  logic [STAGES-1:0][WIDTH-1:0]  dat_d;
  logic [STAGES-1:0][WIDTH-1:0]  up_dat;
  logic [STAGES-1:0]             up_vld;
  logic [STAGES-1:0]             up_hold;
  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             kill;
  logic [OCC_W-1:0]              occ_q;
  logic [OCC_W-1:0]              occ_d;
  logic [CNT_W-1:0]              cnt_q;
  logic                          bp;
  logic                          accept;

  assign bp = vld_q[STAGES-1] & ~out_ready;

  // An older stall or flush reaches every younger stage.
  always_comb begin
    hold = '0;
    kill = '0;
    for (int i = 0; i < STAGES; i++) begin
      hold[i] = bp | (|(stall_req >> i));
      kill[i] = |(flush >> i);
    end
  end

  assign in_ready = ~hold[0] & ~(|flush);
  assign accept   = in_valid & in_ready;

  // What each stage would load from its upstream neighbour.
  assign up_hold = {hold[STAGES-2:0], 1'b0};
  assign up_vld  = {vld_q[STAGES-2:0], accept};
  assign up_dat  = {dat_q[STAGES-2:0], accept ? in_data : NOP};

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      priority case (1'b1)
        kill[i]: begin
          vld_d[i] = 1'b0;
          dat_d[i] = NOP;
        end
        hold[i]: begin
          vld_d[i] = vld_q[i];
          dat_d[i] = dat_q[i];
        end
        up_hold[i]: begin
          vld_d[i] = 1'b0;
          dat_d[i] = NOP;
        end
        default: begin
          vld_d[i] = up_vld[i];
          dat_d[i] = up_dat[i];
        end
      endcase
      occ_d = occ_d + OCC_W'(vld_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= {STAGES{NOP}};
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      occ_q <= occ_d;
      if (cnt_clr)
        cnt_q <= '0;
      else if (hold[0] && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = vld_q[STAGES-1];
  assign out_data    = dat_q[STAGES-1];
  assign stage_valid = vld_q;
  assign stage_data  = dat_q;
  assign occupancy   = occ_q;
  assign stall_count = cnt_q;

endmodule
